// File: rtl/delta_pulse_src_if.sv
// Pixel stream bus for delta_pulse_src: data, valid/ready handshake and
// frame/line markers. The master drives the pixel side, the slave drives ready.
interface delta_pulse_src_if #(
  parameter int G_PIX_W = 8
) ();
  logic [G_PIX_W-1:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_sof;
  logic               m_eol;

  modport master (
    output m_data,
    output m_valid,
    output m_sof,
    output m_eol,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_sof,
    input  m_eol,
    output m_ready
  );
endinterface

// File: rtl/delta_pulse_src.sv
// delta_pulse_src: test-pattern source that emits frames of pixels which are
// zero everywhere except a short symmetric pulse (255,192,100,32) centred on
// (cx,cy). Lines are separated by G_HBLANK idle cycles and frames by
// G_VBLANK idle cycles. G_HBLANK and G_VBLANK are expected to be at least 1.
// All stream outputs are registered; their next values are derived from the
// next FSM state and position, so a stalled pixel holds without extra logic.
module delta_pulse_src #(
  parameter int G_PIX_W  = 8,
  parameter int G_HBLANK = 4,
  parameter int G_VBLANK = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [11:0]         cfg_w,
  input  logic [11:0]         cfg_h,
  input  logic [11:0]         cfg_cx,
  input  logic [11:0]         cfg_cy,
  input  logic [7:0]          cfg_frames,
  input  logic                stop,
  output logic                busy,
  delta_pulse_src_if.master   m
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LINE   = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_VBLANK = 2'd3;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(G_HBLANK - 1);
  localparam logic [CNT_W-1:0] VBLANK_LAST = CNT_W'(G_VBLANK - 1);

  // Pulse value at (px,py). A centre outside the frame gives an all-zero
  // frame, so a centre just past the right edge must not leak its taps in.
  function automatic logic [7:0] pulse_value(
    input logic [11:0] px,
    input logic [11:0] py,
    input logic [11:0] pw,
    input logic [11:0] ph,
    input logic [11:0] pcx,
    input logic [11:0] pcy
  );
    logic [11:0] dx;
    logic [7:0]  val;
    dx  = (px >= pcx) ? (px - pcx) : (pcx - px);
    val = 8'd0;
    if ((pcx < pw) && (pcy < ph) && (py == pcy)) begin
      case (dx)
        12'd0:   val = 8'd255;
        12'd1:   val = 8'd192;
        12'd2:   val = 8'd100;
        12'd3:   val = 8'd32;
        default: val = 8'd0;
      endcase
    end else begin
      val = 8'd0;
    end
    return val;
  endfunction

  logic [1:0]         state_r,  state_s;
  logic [11:0]        w_r,      w_s;
  logic [11:0]        h_r,      h_s;
  logic [11:0]        cx_r,     cx_s;
  logic [11:0]        cy_r,     cy_s;
  logic [7:0]         frames_r, frames_s;
  logic [11:0]        x_r,      x_s;
  logic [11:0]        y_r,      y_s;
  logic [CNT_W-1:0]   blank_r,  blank_s;
  logic [7:0]         fcnt_r,   fcnt_s;
  logic               stop_r,   stop_s;
  logic [7:0]         fcnt_inc_s;

  logic [G_PIX_W-1:0] data_r,   data_s;
  logic               valid_r,  valid_s;
  logic               sof_r,    sof_s;
  logic               eol_r,    eol_s;
  logic               busy_r,   busy_s;

  // Next-state logic: config latch, raster position, blanking and frame count.
  always_comb begin
    state_s    = state_r;
    w_s        = w_r;
    h_s        = h_r;
    cx_s       = cx_r;
    cy_s       = cy_r;
    frames_s   = frames_r;
    x_s        = x_r;
    y_s        = y_r;
    blank_s    = blank_r;
    fcnt_s     = fcnt_r;
    stop_s     = stop_r | stop;
    fcnt_inc_s = (fcnt_r == 8'hFF) ? fcnt_r : (fcnt_r + 8'd1);

    case (state_r)
      ST_IDLE: begin
        stop_s = 1'b0;
        if (start && (cfg_w != 12'd0) && (cfg_h != 12'd0)) begin
          w_s      = cfg_w;
          h_s      = cfg_h;
          cx_s     = cfg_cx;
          cy_s     = cfg_cy;
          frames_s = cfg_frames;
          x_s      = 12'd0;
          y_s      = 12'd0;
          fcnt_s   = 8'd0;
          state_s  = ST_LINE;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_LINE: begin
        if (valid_r && m.m_ready) begin
          if (x_r == (w_r - 12'd1)) begin
            x_s     = 12'd0;
            blank_s = {CNT_W{1'b0}};
            if (y_r == (h_r - 12'd1)) begin
              state_s = ST_VBLANK;
            end else begin
              y_s     = y_r + 12'd1;
              state_s = ST_HBLANK;
            end
          end else begin
            x_s = x_r + 12'd1;
          end
        end else begin
          state_s = ST_LINE;
        end
      end

      ST_HBLANK: begin
        if (blank_r == HBLANK_LAST) begin
          state_s = ST_LINE;
        end else begin
          blank_s = blank_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_VBLANK: begin
        if (blank_r == VBLANK_LAST) begin
          fcnt_s = fcnt_inc_s;
          if (stop_r || stop || ((frames_r != 8'd0) && (fcnt_inc_s == frames_r))) begin
            state_s = ST_IDLE;
            stop_s  = 1'b0;
          end else begin
            state_s = ST_LINE;
            x_s     = 12'd0;
            y_s     = 12'd0;
          end
        end else begin
          blank_s = blank_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_s = ST_IDLE;
        stop_s  = 1'b0;
      end
    endcase
  end

  // Output values for the coming cycle, taken from the next position.
  always_comb begin
    valid_s = (state_s == ST_LINE);
    busy_s  = (state_s != ST_IDLE);
    if (valid_s) begin
      data_s = G_PIX_W'(pulse_value(x_s, y_s, w_s, h_s, cx_s, cy_s));
      sof_s  = (x_s == 12'd0) && (y_s == 12'd0);
      eol_s  = (x_s == (w_s - 12'd1));
    end else begin
      data_s = {G_PIX_W{1'b0}};
      sof_s  = 1'b0;
      eol_s  = 1'b0;
    end
  end

  // State, configuration, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      w_r      <= 12'd0;
      h_r      <= 12'd0;
      cx_r     <= 12'd0;
      cy_r     <= 12'd0;
      frames_r <= 8'd0;
      x_r      <= 12'd0;
      y_r      <= 12'd0;
      blank_r  <= {CNT_W{1'b0}};
      fcnt_r   <= 8'd0;
      stop_r   <= 1'b0;
      data_r   <= {G_PIX_W{1'b0}};
      valid_r  <= 1'b0;
      sof_r    <= 1'b0;
      eol_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      w_r      <= w_s;
      h_r      <= h_s;
      cx_r     <= cx_s;
      cy_r     <= cy_s;
      frames_r <= frames_s;
      x_r      <= x_s;
      y_r      <= y_s;
      blank_r  <= blank_s;
      fcnt_r   <= fcnt_s;
      stop_r   <= stop_s;
      data_r   <= data_s;
      valid_r  <= valid_s;
      sof_r    <= sof_s;
      eol_r    <= eol_s;
      busy_r   <= busy_s;
    end
  end

  assign m.m_data  = data_r;
  assign m.m_valid = valid_r;
  assign m.m_sof   = sof_r;
  assign m.m_eol   = eol_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_delta_pulse_src.sv
// Self-checking bench for delta_pulse_src: a queue of expected pixels built
// from the pulse rules, one negedge compare process, and directed scenarios.
module tb_delta_pulse_src;

  localparam int PW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] cfg_w = 12'd0;
  logic [11:0] cfg_h = 12'd0;
  logic [11:0] cfg_cx = 12'd0;
  logic [11:0] cfg_cy = 12'd0;
  logic [7:0]  cfg_frames = 8'd0;
  logic        busy;

  delta_pulse_src_if #(.G_PIX_W(PW)) bus ();

  delta_pulse_src #(.G_PIX_W(PW), .G_HBLANK(4), .G_VBLANK(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_frames(cfg_frames), .stop(stop),
    .busy(busy), .m(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic sof; logic eol; } pix_t;
  pix_t exp_q[$];

  int total = 0;
  int bad = 0;

  int pix_cnt = 0;
  int sof_cnt = 0;
  int eol_cnt = 0;
  int cap[0:2047];
  int gaps[$];
  int cur_gap = 0;
  logic chk_en = 1'b0;
  logic rand_mode = 1'b0;
  logic prev_stall = 1'b0;
  logic [10:0] prev_vec = 11'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_pix(int x, int y, int w, int h, int cx, int cy);
    int taps[4];
    int dx;
    taps[0] = 255; taps[1] = 192; taps[2] = 100; taps[3] = 32;
    if (cx >= w || cy >= h || y != cy) return 0;
    dx = (x > cx) ? x - cx : cx - x;
    return (dx < 4) ? taps[dx] : 0;
  endfunction

  task automatic push_frame(int w, int h, int cx, int cy);
    pix_t p;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        p.d   = 8'(model_pix(x, y, w, h, cx, cy));
        p.sof = (x == 0 && y == 0);
        p.eol = (x == w - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Compare process: stream contents against the model, stall stability, stats.
  always @(negedge clk) begin
    pix_t e;
    if (chk_en) begin
      if (prev_stall) begin
        chk("stall_hold", {bus.m_valid, bus.m_sof, bus.m_eol, bus.m_data}, prev_vec);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_pixel: got data %0d with no pixel expected", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", {bus.m_sof, bus.m_eol, bus.m_data}, {e.sof, e.eol, e.d});
        end
        if (pix_cnt < 2048) cap[pix_cnt] = int'(bus.m_data);
        pix_cnt++;
        if (bus.m_sof) sof_cnt++;
        if (bus.m_eol) eol_cnt++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_vec   = {bus.m_valid, bus.m_sof, bus.m_eol, bus.m_data};
      if (busy && !bus.m_valid) begin
        cur_gap++;
      end else if (cur_gap > 0) begin
        gaps.push_back(cur_gap);
        cur_gap = 0;
      end
    end
  end

  // Random backpressure driver.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      bus.m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats;
    pix_cnt = 0; sof_cnt = 0; eol_cnt = 0; cur_gap = 0;
    gaps.delete();
    prev_stall = 1'b0;
  endtask

  task automatic do_start(int w, int h, int cx, int cy, int frames);
    cfg_w = 12'(w); cfg_h = 12'(h); cfg_cx = 12'(cx); cfg_cy = 12'(cy);
    cfg_frames = 8'(frames);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(int max, input string name);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
    step(2);
  endtask

  initial begin
    int row12[7];
    int clip[8];
    int n;
    row12[0] = 32; row12[1] = 100; row12[2] = 192; row12[3] = 255;
    row12[4] = 192; row12[5] = 100; row12[6] = 32;
    clip[0] = 255; clip[1] = 192; clip[2] = 100; clip[3] = 32;
    clip[4] = 0; clip[5] = 0; clip[6] = 0; clip[7] = 0;
    bus.m_ready = 1'b1;

    // Reset state
    step(3);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_sof", bus.m_sof, 0);
    chk("rst_eol", bus.m_eol, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step(2);
    chk_en = 1'b1;

    // Basic 25x25 frame
    clear_stats();
    push_frame(25, 25, 12, 12);
    do_start(25, 25, 12, 12, 1);
    @(negedge clk);
    chk("latency", bus.m_valid, 1);
    wait_idle(2000, "basic_idle");
    chk("basic_pixels", pix_cnt, 625);
    chk("basic_sof", sof_cnt, 1);
    chk("basic_eol", eol_cnt, 25);
    for (int i = 0; i < 7; i++) chk("row12_tap", cap[309 + i], row12[i]);
    chk("row12_left0", cap[308], 0);
    chk("row12_right0", cap[316], 0);
    chk("corner0", cap[0], 0);
    chk("gap_count", gaps.size(), 25);
    if (gaps.size() == 25) begin
      for (int i = 0; i < 24; i++) chk("hblank_len", gaps[i], 4);
      chk("vblank_len", gaps[24], 16);
    end
    chk("basic_drain", exp_q.size(), 0);

    // Same frame under random backpressure
    clear_stats();
    push_frame(25, 25, 12, 12);
    rand_mode = 1'b1;
    do_start(25, 25, 12, 12, 1);
    wait_idle(6000, "bp_idle");
    rand_mode = 1'b0;
    step(1);
    bus.m_ready = 1'b1;
    chk("bp_pixels", pix_cnt, 625);
    chk("bp_drain", exp_q.size(), 0);

    // Left-edge clip
    clear_stats();
    push_frame(8, 2, 0, 1);
    do_start(8, 2, 0, 1, 1);
    wait_idle(200, "clip_idle");
    for (int i = 0; i < 8; i++) chk("clip_row1", cap[8 + i], clip[i]);
    chk("clip_row0", cap[0], 0);

    // 1x1 frame
    clear_stats();
    push_frame(1, 1, 0, 0);
    do_start(1, 1, 0, 0, 1);
    wait_idle(100, "one_idle");
    chk("one_pixels", pix_cnt, 1);
    chk("one_value", cap[0], 255);
    chk("one_sof", sof_cnt, 1);
    chk("one_eol", eol_cnt, 1);

    // Starts with a zero dimension are ignored
    clear_stats();
    do_start(0, 5, 0, 0, 1);
    step(1);
    chk("w0_busy", busy, 0);
    do_start(5, 0, 0, 0, 1);
    step(3);
    chk("h0_busy", busy, 0);
    chk("zero_dim_pixels", pix_cnt, 0);

    // Restart attempt mid-frame with different config
    clear_stats();
    push_frame(4, 3, 1, 1);
    do_start(4, 3, 1, 1, 1);
    step(3);
    do_start(8, 8, 2, 2, 1);
    wait_idle(200, "restart_idle");
    chk("restart_sof", sof_cnt, 1);
    chk("restart_pixels", pix_cnt, 12);

    // Centre one column past the right edge -> all-zero frame
    clear_stats();
    push_frame(8, 2, 8, 0);
    do_start(8, 2, 8, 0, 1);
    wait_idle(200, "cxout_idle");
    chk("cxout_pixels", pix_cnt, 16);

    // Two-frame sequence
    clear_stats();
    push_frame(3, 2, 1, 0);
    push_frame(3, 2, 1, 0);
    do_start(3, 2, 1, 0, 2);
    wait_idle(300, "two_idle");
    chk("two_sof", sof_cnt, 2);
    chk("two_drain", exp_q.size(), 0);

    // Continuous mode with stop during frame 3
    clear_stats();
    for (int f = 0; f < 3; f++) push_frame(4, 2, 2, 1);
    do_start(4, 2, 2, 1, 0);
    n = 0;
    while (!(sof_cnt >= 3 && pix_cnt >= 19) && n < 500) begin
      step(1);
      n++;
    end
    chk("cont_reach_f3", sof_cnt, 3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_idle(500, "cont_idle");
    chk("cont_sof", sof_cnt, 3);
    chk("cont_drain", exp_q.size(), 0);

    // Reset mid-frame
    clear_stats();
    push_frame(25, 25, 12, 12);
    do_start(25, 25, 12, 12, 1);
    step(30);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", bus.m_data, 0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    clear_stats();
    chk_en = 1'b1;
    step(20);
    chk("postrst_pixels", pix_cnt, 0);
    chk("postrst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/delta_pulse_src.md
DELTA_PULSE_SRC -- requirements
Module: delta_pulse_src

Interface
REQ-001 Parameter G_PIX_W, default 8: pixel data width in bits, minimum 8.
REQ-002 Parameter G_HBLANK, default 4: idle cycles inserted after each line.
REQ-003 Parameter G_VBLANK, default 16: idle cycles inserted after each frame.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port start, input, 1: single-cycle request to begin a frame sequence.
REQ-007 Port cfg_w, input, 12: frame width in pixels.
REQ-008 Port cfg_h, input, 12: frame height in lines.
REQ-009 Port cfg_cx, input, 12: pulse centre column.
REQ-010 Port cfg_cy, input, 12: pulse centre row.
REQ-011 Port cfg_frames, input, 8: number of frames to emit; 0 means continuous until stop.
REQ-012 Port stop, input, 1: request to end the sequence at the next frame boundary.
REQ-013 Port m_data, output, G_PIX_W: pixel value.
REQ-014 Port m_valid, output, 1: m_data is valid.
REQ-015 Port m_ready, input, 1: downstream accepts the pixel.
REQ-016 Port m_sof, output, 1: qualifies the first pixel of a frame.
REQ-017 Port m_eol, output, 1: qualifies the last pixel of a line.
REQ-018 Port busy, output, 1: high from the accepted start until return to IDLE.

Function
REQ-019 FSM states SHALL be IDLE, LINE, HBLANK and VBLANK.
REQ-020 In IDLE, a start with cfg_w>0 and cfg_h>0 SHALL latch all cfg_* inputs, enter LINE on the next cycle and set busy.
REQ-021 In IDLE, a start with cfg_w=0 or cfg_h=0 SHALL be ignored.
REQ-022 A start received outside IDLE SHALL be ignored.
REQ-023 cfg_* changes after the latch SHALL have no effect until the next accepted start.
REQ-024 In LINE, m_valid SHALL be 1.
REQ-025 x SHALL advance only on m_valid&m_ready.
REQ-026 While m_valid=1 and m_ready=0, m_data, m_sof and m_eol SHALL hold stable.
REQ-027 Pixel value at (x,y), with dx=|x-cx|: y=cy and dx=0 -> 255.
REQ-028 Pixel value at (x,y), with dx=|x-cx|: y=cy and dx=1 -> 192.
REQ-029 Pixel value at (x,y), with dx=|x-cx|: y=cy and dx=2 -> 100.
REQ-030 Pixel value at (x,y), with dx=|x-cx|: y=cy and dx=3 -> 32.
REQ-031 Pixel value at (x,y), with dx=|x-cx|: otherwise 0.
REQ-032 Pixel values SHALL be zero-extended to G_PIX_W.
REQ-033 Taps that fall outside 0..w-1 SHALL simply not appear.
REQ-034 A cx or cy outside the frame SHALL yield an all-zero frame with no error.
REQ-035 m_sof SHALL be 1 only at x=0,y=0; m_eol SHALL be 1 only at x=w-1.
REQ-036 When w=1, m_sof and m_eol SHALL both be 1 on the same pixel of row 0.
REQ-037 On transfer of the eol pixel with y<h-1: y+1, x=0, enter HBLANK for exactly G_HBLANK cycles with m_valid=0, then return to LINE.
REQ-038 On transfer of the eol pixel with y=h-1: enter VBLANK for exactly G_VBLANK cycles with m_valid=0.
REQ-039 At the end of VBLANK, the frame counter SHALL increment.
REQ-040 At the end of VBLANK, return to IDLE if stop was latched or if cfg_frames!=0 and the count equals cfg_frames; otherwise enter LINE at (0,0).
REQ-041 A stop pulse at any time while busy SHALL be latched and cleared on the return to IDLE.
REQ-042 Latency from an accepted start to the first m_valid SHALL be 1 cycle.
REQ-043 Throughput SHALL be 1 pixel per clock while m_ready=1.
REQ-044 The 8-bit frame counter SHALL saturate in continuous mode and never terminate the sequence by itself.

Reset
REQ-045 rst_n=0 SHALL asynchronously force the FSM to IDLE and clear all counters, latched configuration and the stop flag.
REQ-046 While rst_n=0, outputs SHALL be m_valid=0, m_data=0, m_sof=0, m_eol=0, busy=0.
REQ-047 Reset asserted mid-frame SHALL abort the frame with no further m_valid.
REQ-048 After rst_n deasserts, the block SHALL require a new start.

Verification
REQ-049 Basic frame: w=25, h=25, cx=12, cy=12, frames=1, m_ready=1 -> 625 pixels; row 12, x=9..15 = 32,100,192,255,192,100,32; all other pixels 0; 24 HBLANK gaps of 4 cycles; busy drops after 16 VBLANK cycles.
REQ-050 Backpressure: random m_ready at 50% -> identical pixel sequence to REQ-049; outputs stable during every stall.
REQ-051 Edge clip: w=8, h=2, cx=0, cy=1 -> row 1 = 255,192,100,32,0,0,0,0; row 0 all zero.
REQ-052 Degenerate: w=1, h=1, start -> one pixel with sof=eol=1; value 255 if cx=cy=0.
REQ-053 Ignored start: start with w=0 -> busy stays 0; start pulse during a frame -> no restart and sof count unchanged.
REQ-054 Continuous/stop: frames=0, stop pulsed mid-frame 3 -> exactly 3 sof pulses, then IDLE; rst_n pulsed mid-frame -> m_valid=0 immediately and busy=0.
